// File: rtl/iir_coeff_ctrl_pkg.sv
// Shared constants for the IIR coefficient controller: coefficient slot order, unity value, FSM codes.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package iir_coeff_ctrl_pkg;

  // Per-section coefficient slot order as streamed over cfg_data.
  localparam int COEFF_B0 = 0;
  localparam int COEFF_B1 = 1;
  localparam int COEFF_B2 = 2;
  localparam int COEFF_A0 = 3;
  localparam int COEFF_A1 = 4;
  localparam int COEFF_A2 = 5;

  // s16.15 value closest to 1.0; b0 = a0 = unity makes a section a pass-through.
  localparam logic [15:0] COEFF_UNITY = 16'h7FFF;

  // Controller states.
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOAD      = 2'd1;
  localparam logic [1:0] ST_WAIT_SWAP = 2'd2;

  // True for the slots that hold unity in the pass-through bank.
  function automatic logic is_unity_idx(input int idx);
    return (idx == COEFF_B0) || (idx == COEFF_A0);
  endfunction

endpackage

// File: rtl/iir_coeff_ctrl_if.sv
// Coefficient configuration port: load request, word stream with ready, done pulse, sticky error.
// Latency: n/a (wires only).
// Backpressure: cfg_ready gates cfg_valid; words offered while cfg_ready is low are not taken.
interface iir_coeff_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  cfg_start;
  logic                  cfg_valid;
  logic [DATA_WIDTH-1:0] cfg_data;
  logic                  cfg_ready;
  logic                  cfg_done;
  logic                  cfg_err;

  // Host side that streams coefficients in.
  modport master (
    output cfg_start, cfg_valid, cfg_data,
    input  cfg_ready, cfg_done, cfg_err
  );

  // Controller side.
  modport slave (
    input  cfg_start, cfg_valid, cfg_data,
    output cfg_ready, cfg_done, cfg_err
  );
endinterface

// File: rtl/iir_sample_tick.sv
// Free-running modulo-DECIM counter producing the filter's sample boundary strobe.
// Latency: first strobe DECIM-1 edges after reset release, then every DECIM clocks.
// Backpressure: none; never stalls.
module iir_sample_tick #(
  parameter int DECIM = 3
) (
  input  logic clk,
  input  logic rst_n,
  output logic sample_en
);
  localparam int CNT_W = $clog2(DECIM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             en_q, en_d;

  // Next count wraps at DECIM-1; strobe is registered so it is high while count == DECIM-1.
  always_comb begin
    count_d = (count_q == CNT_LAST) ? '0 : count_q + CNT_W'(1);
    en_d    = (count_d == CNT_LAST);
  end

  // Counter and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      en_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      en_q    <= en_d;
    end
  end

  assign sample_en = en_q;

endmodule

// File: rtl/iir_coeff_ctrl.sv
// Loads biquad coefficients into a shadow bank and swaps it into the active bank on a sample boundary.
// Latency: one word per clock; swap 1..DECIM clocks after the last word, cfg_done the cycle after the swap.
// Backpressure: cfg_ready high only while loading; words outside a load raise the sticky cfg_err.
module iir_coeff_ctrl
  import iir_coeff_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_SECTIONS   = 3,
  parameter int COEFFS_PER_SEC = 6,
  parameter int DECIM          = 3
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  iir_coeff_ctrl_if.slave                                   cfg,
  output logic                                              sample_en,
  output logic [NUM_SECTIONS*COEFFS_PER_SEC*DATA_WIDTH-1:0] coeff_active
);
  localparam int NUM_COEFFS = NUM_SECTIONS * COEFFS_PER_SEC;
  localparam int BANK_W     = NUM_COEFFS * DATA_WIDTH;
  localparam int IDX_W      = $clog2(NUM_COEFFS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFFS - 1);

  // Every section passes its input straight through: b0 = a0 = unity, rest zero.
  function automatic logic [BANK_W-1:0] pass_through_bank();
    logic [BANK_W-1:0] bank;
    bank = '0;
    for (int k = 0; k < NUM_COEFFS; k++) begin
      if (is_unity_idx(k % COEFFS_PER_SEC)) begin
        bank[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(COEFF_UNITY);
      end
    end
    return bank;
  endfunction

  localparam logic [BANK_W-1:0] ACTIVE_RST = pass_through_bank();

  logic [1:0]        state_q,  state_d;
  logic [IDX_W-1:0]  idx_q,    idx_d;
  logic [BANK_W-1:0] shadow_q, shadow_d;
  logic [BANK_W-1:0] active_q, active_d;
  logic              ready_q,  ready_d;
  logic              done_q,   done_d;
  logic              err_q,    err_d;

  iir_sample_tick #(
    .DECIM (DECIM)
  ) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample_en (sample_en)
  );

  // Load/swap sequencing; shadow only reaches active on a sample_en cycle in WAIT_SWAP.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    active_d = active_q;
    err_d    = err_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg.cfg_start) begin
          // A word presented alongside start is dropped; the load begins next cycle.
          state_d = ST_LOAD;
          idx_d   = '0;
          err_d   = 1'b0;
        end else if (cfg.cfg_valid) begin
          err_d = 1'b1;
        end
      end
      ST_LOAD: begin
        if (cfg.cfg_start) begin
          // Restart: earlier shadow words stay until overwritten by the new stream.
          idx_d = '0;
        end else if (cfg.cfg_valid) begin
          shadow_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = cfg.cfg_data;
          if (idx_q == LAST_IDX) begin
            state_d = ST_WAIT_SWAP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_WAIT_SWAP: begin
        if (cfg.cfg_start || cfg.cfg_valid) begin
          err_d = 1'b1;
        end
        if (sample_en) begin
          active_d = shadow_q;
          state_d  = ST_IDLE;
          done_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
    ready_d = (state_d == ST_LOAD);
  end

  // State, banks and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      active_q <= ACTIVE_RST;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_done  = done_q;
  assign cfg.cfg_err   = err_q;
  assign coeff_active  = active_q;

endmodule

// File: tb/tb_iir_coeff_ctrl.sv
// Scoreboard bench for iir_coeff_ctrl: stimulus pushes expected banks and swap cycles, a monitor pops on cfg_done.
// Latency: expected swap is the first sample boundary at or after the cycle following the last word.
// Backpressure: driver only streams while the controller is expected to be loading.
module tb_iir_coeff_ctrl;
  localparam int DW    = 16;
  localparam int NS    = 3;
  localparam int CPS   = 6;
  localparam int DECIM = 3;
  localparam int NC    = NS * CPS;
  localparam int BW    = NC * DW;

  typedef struct {
    logic [BW-1:0] bank;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_en;
  logic [BW-1:0] coeff_active;
  int            cyc;
  int            checks = 0;
  int            failures = 0;
  exp_t          sb_q[$];
  logic [BW-1:0] exp_active;

  iir_coeff_ctrl_if #(.DATA_WIDTH(DW)) cfg_if ();

  iir_coeff_ctrl #(
    .DATA_WIDTH     (DW),
    .NUM_SECTIONS   (NS),
    .COEFFS_PER_SEC (CPS),
    .DECIM          (DECIM)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg          (cfg_if),
    .sample_en    (sample_en),
    .coeff_active (coeff_active)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; sample boundaries are cycles with cyc % DECIM == DECIM-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [BW-1:0] pass_bank();
    logic [BW-1:0] b;
    b = '0;
    for (int k = 0; k < NC; k++) begin
      if ((k % CPS) == 0 || (k % CPS) == 3) b[k*DW +: DW] = 16'h7FFF;
    end
    return b;
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: sample_en phase, cfg_done against the scoreboard, and active bank stability.
  initial begin
    exp_active = pass_bank();
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        exp_active = pass_bank();
        chk("rst_coeff_active", coeff_active, exp_active);
        chk("rst_sample_en", BW'(sample_en), '0);
        chk("rst_done", BW'(cfg_if.cfg_done), '0);
        chk("rst_ready", BW'(cfg_if.cfg_ready), '0);
        chk("rst_err", BW'(cfg_if.cfg_err), '0);
      end else begin
        chk("sample_en", BW'(sample_en), BW'((cyc % DECIM) == DECIM - 1));
        if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
          checks++;
          failures++;
          $display("FAIL done_missing: no cfg_done by cycle %0d, required at %0d", cyc, sb_q[0].cyc);
          exp_active = sb_q[0].bank;
          sb_q.delete(0);
        end
        if (cfg_if.cfg_done) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL done_unexpected: cfg_done=1 at cycle %0d, required 0", cyc);
          end else begin
            chk("done_cycle", BW'(cyc), BW'(sb_q[0].cyc));
            exp_active = sb_q[0].bank;
            sb_q.delete(0);
          end
        end
        chk("coeff_active", coeff_active, exp_active);
      end
    end
  end

  // One load: start, optional aborted prefix, 18 words, then swap expectation / error / reset variants.
  task automatic do_load(input int base, input bit throttle, input int abort_words,
                         input bit start_with_valid, input bit start_in_wait, input bit reset_in_wait);
    logic [BW-1:0] bank;
    logic [DW-1:0] word;
    int            last_edge;
    int            m;
    bank = '0;
    last_edge = 0;
    @(negedge clk);
    cfg_if.cfg_start = 1'b1;
    cfg_if.cfg_valid = start_with_valid;
    cfg_if.cfg_data  = 16'($urandom);
    @(negedge clk);
    cfg_if.cfg_start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    chk("ready_after_start", BW'(cfg_if.cfg_ready), BW'(1));
    chk("err_clear_on_start", BW'(cfg_if.cfg_err), '0);
    if (abort_words > 0) begin
      for (int k = 0; k < abort_words; k++) begin
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = 16'($urandom);
        @(negedge clk);
      end
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_start = 1'b1;
      @(negedge clk);
      cfg_if.cfg_start = 1'b0;
      chk("ready_after_abort", BW'(cfg_if.cfg_ready), BW'(1));
    end
    for (int k = 0; k < NC; k++) begin
      if (throttle && k > 0) begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = 16'($urandom);
        @(negedge clk);
      end
      word = (base < 0) ? 16'($urandom) : 16'(base + k);
      bank[k*DW +: DW] = word;
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_data  = word;
      if (k == NC - 1) last_edge = cyc + 1;
      @(negedge clk);
    end
    cfg_if.cfg_valid = 1'b0;
    chk("ready_after_last", BW'(cfg_if.cfg_ready), '0);
    if (reset_in_wait) begin
      rst_n = 1'b0;
      sb_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", BW'(cfg_if.cfg_ready), '0);
      chk("err_after_reset", BW'(cfg_if.cfg_err), '0);
      repeat (4) @(negedge clk);
    end else begin
      m = last_edge;
      while ((m % DECIM) != DECIM - 1) m++;
      sb_q.push_back('{bank: bank, cyc: m + 1});
      if (start_in_wait) begin
        cfg_if.cfg_start = 1'b1;
        @(negedge clk);
        cfg_if.cfg_start = 1'b0;
        chk("err_start_in_wait", BW'(cfg_if.cfg_err), BW'(1));
        chk("ready_start_in_wait", BW'(cfg_if.cfg_ready), '0);
      end
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    cfg_if.cfg_start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_idle", BW'(cfg_if.cfg_ready), '0);
    chk("err_idle", BW'(cfg_if.cfg_err), '0);
    repeat (4) @(negedge clk);

    // Stray word in IDLE raises the sticky error and must not touch the bank.
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = 16'hDEAD;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    chk("err_valid_idle", BW'(cfg_if.cfg_err), BW'(1));
    @(negedge clk);
    chk("err_sticky", BW'(cfg_if.cfg_err), BW'(1));

    do_load(32'h0100, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    do_load(32'h0300, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    do_load(32'h0200, 1'b0, 7, 1'b0, 1'b0, 1'b0);
    do_load(-1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("err_sticky_after_swap", BW'(cfg_if.cfg_err), BW'(1));

    for (int i = 0; i < 6; i++) begin
      repeat (i % 3) @(negedge clk);
      do_load(-1, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    do_load(-1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    do_load(32'h0400, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    repeat (6) @(negedge clk);
    chk("sb_drained", BW'(sb_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500us, required to finish");
    $fatal(1);
  end

endmodule

// File: doc/iir_coeff_ctrl.md
# iir_coeff_ctrl

Coefficient configuration and sample-rate sequencing controller for the Cascaded_IIR notch filter. It generates the sample-enable strobe that tells the filter when a new input sample is valid: one strobe every DECIM clocks, i.e. 6 MS/s from the 18 MHz `clk`. It accepts a serial stream of biquad coefficients into a shadow bank, then swaps that bank into the active bank the filter reads. The swap happens only on a sample boundary, so the filter never mixes old and new coefficients within one sample.

## Interface
Parameters:
- DATA_WIDTH, 16, coefficient width, s16.15 signed.
- NUM_SECTIONS, 3, cascaded biquad sections.
- COEFFS_PER_SEC, 6, per-section order b0, b1, b2, a0, a1, a2.
- DECIM, 3, clocks per input sample (≥2).

Ports:
- clk  in  1  system clock, 18 MHz.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  one-cycle request to begin a new coefficient load.
- cfg_valid  in  1  cfg_data valid.
- cfg_data  in  DATA_WIDTH  coefficient word, section 0 b0 first.
- cfg_ready  out  1  controller accepts cfg_data this cycle.
- cfg_done  out  1  one-cycle pulse in the cycle after the active bank updates.
- cfg_err  out  1  sticky protocol error flag; cleared by cfg_start in IDLE.
- sample_en  out  1  one-cycle strobe marking the sample boundary.
- coeff_active  out  NUM_SECTIONS*COEFFS_PER_SEC*DATA_WIDTH  flattened active bank; index k at bits [k*DATA_WIDTH +: DATA_WIDTH], k = sec*COEFFS_PER_SEC + idx.

## Operation
- Sample counter: modulo-DECIM counter. sample_en = 1 when count == DECIM-1. The counter free-runs and is unaffected by configuration activity.
- FSM has three states: IDLE, LOAD, WAIT_SWAP.
- IDLE:
  - cfg_start → LOAD, word index reset to 0, cfg_err cleared.
  - cfg_valid with no start → cfg_err set; data ignored.
- LOAD:
  - cfg_ready = 1.
  - Each cfg_valid&&cfg_ready cycle writes cfg_data into shadow[index] and increments the index.
  - Accepting word NUM_SECTIONS*COEFFS_PER_SEC-1 (17 by default) → WAIT_SWAP.
  - cfg_start in LOAD aborts: index is reset to 0 and the state stays LOAD. Shadow words already written are kept but will be overwritten.
- WAIT_SWAP:
  - cfg_ready = 0.
  - On the first cycle with sample_en = 1, shadow is copied to active at that clock edge → IDLE, and cfg_done pulses in the following cycle.
  - cfg_start or cfg_valid in WAIT_SWAP → cfg_err set; the request is ignored.
- Shadow is never visible on coeff_active until the swap. Partial loads never reach the active bank.
- Simultaneous cfg_start and cfg_valid in IDLE: the start is taken and the data word is not written.

## Timing
- Reset values:
  - count = 0; state IDLE; index 0.
  - sample_en, cfg_ready, cfg_done, cfg_err = 0.
  - Shadow all 0.
  - Active bank = pass-through per section: b0 = a0 = 16'h7FFF, all others 0.
- First sample_en occurs DECIM-1 rising edges after rst_n deasserts, then every DECIM cycles.
- Load throughput is one word per clock. Minimum load time is 18 cycles from the first accepted word.
- Swap latency after the last word is 1 to DECIM cycles (waits for the next sample_en). If the last word is accepted in the same cycle as sample_en, the swap waits for the next sample_en.
- coeff_active changes only in the cycle after a sample_en edge. All outputs are registered.
- Reset mid-load or in WAIT_SWAP: everything returns to reset values, including the active bank.

## Structure
- Shared package: per-section coefficient index constants (B0..A2 = 0..5) and the pass-through reset constant 16'h7FFF.
- One sub-module: iir_sample_tick, the modulo-DECIM counter with a sample_en output.
- Shadow and active banks are flat register arrays in the top module. No RAM is needed.

## Test plan
- Reset release: rst_n low then high → sample_en pulses at edges 2, 5, 8, …; coeff_active = pass-through pattern; cfg_ready = 0.
- Full load: cfg_start, then 18 consecutive words 16'h0100..16'h0111 → cfg_ready drops after the 18th word. coeff_active is unchanged until the next sample_en, then word k = 16'h0100+k, and cfg_done pulses exactly once the cycle after.
- Throttled load: cfg_valid toggling 1/0 across 18 words → same final bank; index advances only on valid&&ready cycles.
- Abort: load 7 words, assert cfg_start, then load 18 words 16'h0200+k → the active bank after the swap is 16'h0200+k for all k.
- Protocol errors:
  - cfg_valid in IDLE → cfg_err = 1 and the bank is unchanged.
  - cfg_start during WAIT_SWAP → cfg_err = 1; the swap still occurs.
  - cfg_start in IDLE → cfg_err cleared.
- Reset mid-operation: assert rst_n low during WAIT_SWAP → the active bank is the pass-through pattern, no cfg_done pulse, and the state is IDLE.
